// File: rtl/rdcla_pipe.sv
// Pipelined recursive-doubling KPG carry-lookahead adder/subtractor, one op per cycle.
// Optional signed-overflow output enabled by defining RDCLA_OVF_EN.
module rdcla_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             hold,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RDCLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int LEVELS = $clog2(WIDTH) + 1;

    localparam logic [1:0] KPG_K = 2'b00;
    localparam logic [1:0] KPG_P = 2'b01;
    localparam logic [1:0] KPG_G = 2'b11;

    logic [WIDTH-1:0]        b_eff;
    logic                    cin_eff;
    logic [WIDTH:0][1:0]     kpg_init;

    // Index 0 is the capture stage; index k+1 holds the output of prefix level k.
    logic [LEVELS:0][WIDTH:0][1:0]   kpg_reg;
    logic [LEVELS-1:0][WIDTH:0][1:0] kpg_next;
    logic [LEVELS:0][WIDTH-1:0]      a_reg;
    logic [LEVELS:0][WIDTH-1:0]      b_reg;
    logic [LEVELS:0]                 valid_reg;
    logic [WIDTH:0]                  carry;

    assign b_eff       = sub ? ~b : b;
    assign cin_eff     = sub | cin;
    assign kpg_init[0] = cin_eff ? KPG_G : KPG_K;

    genvar gi, gl;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_init
            assign kpg_init[gi+1] = (a[gi] & b_eff[gi]) ? KPG_G :
                                    ((a[gi] | b_eff[gi]) ? KPG_P : KPG_K);
        end

        for (gl = 0; gl < LEVELS; gl++) begin : g_level
            for (gi = 0; gi <= WIDTH; gi++) begin : g_pos
                if (gi >= (1 << gl)) begin : g_cell
                    // A resolved K/G keeps its value; P defers to the lower span.
                    assign kpg_next[gl][gi] = (kpg_reg[gl][gi] == KPG_P) ?
                                              kpg_reg[gl][gi-(1<<gl)] : kpg_reg[gl][gi];
                end else begin : g_pass
                    assign kpg_next[gl][gi] = kpg_reg[gl][gi];
                end
            end
        end

        for (gi = 0; gi <= WIDTH; gi++) begin : g_carry
            assign carry[gi] = (kpg_reg[LEVELS][gi] == KPG_G);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            kpg_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else if (!hold) begin
            valid_reg[0] <= in_valid;
            kpg_reg[0]   <= kpg_init;
            a_reg[0]     <= a;
            b_reg[0]     <= b_eff;
            for (int k = 1; k <= LEVELS; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                kpg_reg[k]   <= kpg_next[k-1];
                a_reg[k]     <= a_reg[k-1];
                b_reg[k]     <= b_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef RDCLA_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (!hold) begin
            out_valid <= valid_reg[LEVELS];
            sum       <= a_reg[LEVELS] ^ b_reg[LEVELS] ^ carry[WIDTH-1:0];
            cout      <= carry[WIDTH];
`ifdef RDCLA_OVF_EN
            ovf       <= carry[WIDTH-1] ^ carry[WIDTH];
`endif
        end
    end

endmodule

// File: tb/tb_rdcla_pipe.sv
// Bench for rdcla_pipe: 32-bit and 8-bit instances driven in lockstep, checked against
// an arithmetic scoreboard plus a directed vector table. Checks ovf when RDCLA_OVF_EN is set.
module tb_rdcla_pipe;

    localparam int LAT32 = 8;
    localparam int LAT8  = 6;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        hold;
    logic        sub;
    logic        cin;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;

    logic        out_valid32, cout32;
    logic [31:0] sum32;
    logic        out_valid8, cout8;
    logic [7:0]  sum8;
`ifdef RDCLA_OVF_EN
    logic        ovf32, ovf8;
`endif

    rdcla_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a32), .b(b32),
        .cin(cin), .sub(sub), .hold(hold),
        .out_valid(out_valid32), .sum(sum32), .cout(cout32)
`ifdef RDCLA_OVF_EN
        , .ovf(ovf32)
`endif
    );

    rdcla_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
        .cin(cin), .sub(sub), .hold(hold),
        .out_valid(out_valid8), .sum(sum8), .cout(cout8)
`ifdef RDCLA_OVF_EN
        , .ovf(ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          rem;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } ent_t;

    ent_t q32[$];
    ent_t q8[$];

    logic        exp32_v = 1'b0, exp32_cout = 1'b0, exp32_ovf = 1'b0;
    logic [31:0] exp32_sum = '0;
    logic        exp8_v = 1'b0, exp8_cout = 1'b0, exp8_ovf = 1'b0;
    logic [31:0] exp8_sum = '0;

    typedef struct {
        logic [31:0] a32, b32;
        logic [7:0]  a8, b8;
        logic        sub, cin;
        logic [31:0] s32;
        logic        c32;
        logic [7:0]  s8;
        logic        c8, v8;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Plain integer arithmetic: result of x + (s ? -y : y + c) in w bits.
    function automatic void ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                    input logic s, input logic c,
                                    output logic [31:0] r, output logic co, output logic ov);
        longint unsigned mask, xv, yv, t;
        mask = (64'd1 << w) - 64'd1;
        xv   = {32'd0, x} & mask;
        yv   = (s ? ~{32'd0, y} : {32'd0, y}) & mask;
        t    = xv + yv + (s ? 64'd1 : {63'd0, c});
        r    = t[31:0] & mask[31:0];
        co   = t[w];
        ov   = (xv[w-1] == yv[w-1]) && (t[w-1] != xv[w-1]);
    endfunction

    task automatic model_edge();
        ent_t e;
        exp32_v = 1'b0;
        exp8_v  = 1'b0;
        foreach (q32[i]) q32[i].rem = q32[i].rem - 1;
        foreach (q8[i])  q8[i].rem  = q8[i].rem - 1;
        if (q32.size() > 0 && q32[0].rem == 0) begin
            e = q32.pop_front();
            exp32_v = 1'b1; exp32_sum = e.sum; exp32_cout = e.cout; exp32_ovf = e.ovf;
            $display("[%0t] w32 result sum=%h cout=%b", $time, e.sum, e.cout);
        end
        if (q8.size() > 0 && q8[0].rem == 0) begin
            e = q8.pop_front();
            exp8_v = 1'b1; exp8_sum = e.sum; exp8_cout = e.cout; exp8_ovf = e.ovf;
        end
        if (in_valid) begin
            e.rem = LAT32 - 1;
            ref_add(32, a32, b32, sub, cin, e.sum, e.cout, e.ovf);
            q32.push_back(e);
            e.rem = LAT8 - 1;
            ref_add(8, {24'd0, a8}, {24'd0, b8}, sub, cin, e.sum, e.cout, e.ovf);
            q8.push_back(e);
        end
    endtask

    task automatic compare_outputs();
        check("valid32", {31'd0, out_valid32}, {31'd0, exp32_v});
        if (exp32_v) begin
            check("sum32", sum32, exp32_sum);
            check("cout32", {31'd0, cout32}, {31'd0, exp32_cout});
`ifdef RDCLA_OVF_EN
            check("ovf32", {31'd0, ovf32}, {31'd0, exp32_ovf});
`endif
        end
        check("valid8", {31'd0, out_valid8}, {31'd0, exp8_v});
        if (exp8_v) begin
            check("sum8", {24'd0, sum8}, exp8_sum);
            check("cout8", {31'd0, cout8}, {31'd0, exp8_cout});
`ifdef RDCLA_OVF_EN
            check("ovf8", {31'd0, ovf8}, {31'd0, exp8_ovf});
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst && !hold) model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid32"}, {31'd0, out_valid32}, 32'd0);
        check({tag, "_sum32"}, sum32, 32'd0);
        check({tag, "_cout32"}, {31'd0, cout32}, 32'd0);
        check({tag, "_valid8"}, {31'd0, out_valid8}, 32'd0);
        check({tag, "_sum8"}, {24'd0, sum8}, 32'd0);
        check({tag, "_cout8"}, {31'd0, cout8}, 32'd0);
`ifdef RDCLA_OVF_EN
        check({tag, "_ovf32"}, {31'd0, ovf32}, 32'd0);
        check({tag, "_ovf8"}, {31'd0, ovf8}, 32'd0);
`endif
    endtask

    // Single isolated operation: exact latency, value and one-cycle out_valid pulse.
    task automatic run_vec(input int idx);
        vec_t v;
        v = tbl[idx];
        $display("[%0t] vec %0d: a32=%h b32=%h a8=%h b8=%h sub=%b cin=%b", $time, idx,
                 v.a32, v.b32, v.a8, v.b8, v.sub, v.cin);
        a32 = v.a32; b32 = v.b32; a8 = v.a8; b8 = v.b8;
        sub = v.sub; cin = v.cin; in_valid = 1'b1; hold = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int e = 2; e <= LAT32 + 1; e++) begin
            tick();
            if (e == LAT8 - 1) check("vec_early8", {31'd0, out_valid8}, 32'd0);
            if (e == LAT8) begin
                check("vec_valid8", {31'd0, out_valid8}, 32'd1);
                check("vec_sum8", {24'd0, sum8}, {24'd0, v.s8});
                check("vec_cout8", {31'd0, cout8}, {31'd0, v.c8});
`ifdef RDCLA_OVF_EN
                check("vec_ovf8", {31'd0, ovf8}, {31'd0, v.v8});
`endif
            end
            if (e == LAT8 + 1) check("vec_pulse8", {31'd0, out_valid8}, 32'd0);
            if (e == LAT32 - 1) check("vec_early32", {31'd0, out_valid32}, 32'd0);
            if (e == LAT32) begin
                check("vec_valid32", {31'd0, out_valid32}, 32'd1);
                check("vec_sum32", sum32, v.s32);
                check("vec_cout32", {31'd0, cout32}, {31'd0, v.c32});
            end
            if (e == LAT32 + 1) check("vec_pulse32", {31'd0, out_valid32}, 32'd0);
        end
    endtask

    task automatic drive_random(input int i);
        a32 = $urandom; b32 = $urandom;
        a8  = 8'($urandom); b8 = 8'($urandom);
        sub = i[0];
        cin = 1'($urandom);
    endtask

    task automatic run_stream(input int n, input int hold_after, input int hold_len,
                              input int bubble_at);
        for (int i = 0; i < n; i++) begin
            if (i == bubble_at) begin
                in_valid = 1'b0;
                tick();
            end
            drive_random(i);
            in_valid = 1'b1;
            hold = 1'b0;
            tick();
            if (i == hold_after - 1) begin
                // Source keeps presenting the next op while stalled; it must be ignored.
                drive_random(i + 1);
                hold = 1'b1;
                for (int h = 0; h < hold_len; h++) tick();
                hold = 1'b0;
            end
        end
        in_valid = 1'b0;
        for (int d = 0; d < LAT32 + 2; d++) tick();
        check("drain32", q32.size(), 32'd0);
        check("drain8", q8.size(), 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 8'h7F, 8'h01, 1'b0, 1'b0,
                   32'h00000000, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[1] = '{32'h00000005, 32'h00000007, 8'h80, 8'h01, 1'b1, 1'b0,
                   32'hFFFFFFFE, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[2] = '{32'h00000007, 32'h00000005, 8'h07, 8'h05, 1'b1, 1'b1,
                   32'h00000002, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[3] = '{32'h12345678, 32'h11111111, 8'hFF, 8'hFF, 1'b0, 1'b1,
                   32'h2345678A, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{32'h00000000, 32'h00000000, 8'h00, 8'h80, 1'b1, 1'b0,
                   32'h00000000, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[5] = '{32'h80000000, 32'h80000000, 8'h80, 8'h80, 1'b0, 1'b0,
                   32'h00000000, 1'b1, 8'h00, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; sub = 1'b0; cin = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        tick();
        tick();
        check_cleared("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i);

        $display("[%0t] stream: 16 back-to-back ops", $time);
        run_stream(16, -1, 0, -1);

        $display("[%0t] stream: 16 ops, 3-cycle hold after 4th, one bubble", $time);
        run_stream(16, 4, 3, 9);

        $display("[%0t] mid-stream reset with 5 ops in flight", $time);
        for (int i = 0; i < 5; i++) begin
            drive_random(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        q32.delete();
        q8.delete();
        exp32_v = 1'b0; exp8_v = 1'b0;
        check_cleared("midrst");
        tick();
        rst = 1'b0;
        for (int d = 0; d < LAT32 + 2; d++) tick();
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
